id_ex_alu_ctrl: RTL and testbench
=================================

ID_EX_ALU_CTRL -- requirements
Module: id_ex_alu_ctrl

Interface
REQ-001 Parameter M, default 32: datapath width of operands and PC.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 StallE  input  1  hold ID/EX register contents.
REQ-005 FlushE  input  1  load a bubble into ID/EX.
REQ-006 ValidD  input  1  decode-stage instruction is valid.
REQ-007 InstrD  input  32  decode-stage instruction word.
REQ-008 RD1D, RD2D, ImmExtD, PCD  input  M each  register-file reads, extended immediate, PC.
REQ-009 ALUOpCodeE  output  4  opcode driven to Execute ALU.
REQ-010 SrcAE, SrcBE  output  M each  ALU operands A and B.
REQ-011 ValidE  output  1  Execute-stage slot holds a real instruction.
REQ-012 IllegalE  output  1  registered instruction was not decodable.

Function
REQ-013 ALU encoding SHALL be: add 0000, sub 0001, xor 0010, or 0011, and 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
REQ-014 R-type (0110011): funct3 000 -> add (funct7 0000000) or sub (0100000); 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl/sra by funct7; 110 or; 111 and.
REQ-015 I-ALU (0010011): same funct3 map without sub; funct3 101 selects srai when imm[11:5]=0100000, srli when 0000000.
REQ-016 Load (0000011), store (0100011), jalr (1100111): add, SrcA=RD1D, SrcB=ImmExtD.
REQ-017 Branch (1100011): funct3 000/001 -> sub; 100/101 -> slt; 110/111 -> sltu; SrcA=RD1D, SrcB=RD2D.
REQ-018 lui (0110111): add, SrcA=0, SrcB=ImmExtD; auipc (0010111): add, SrcA=PCD, SrcB=ImmExtD; jal (1101111): add, SrcA=PCD, SrcB=ImmExtD.
REQ-019 R-type SrcA=RD1D, SrcB=RD2D; I-ALU SrcA=RD1D, SrcB=ImmExtD.
REQ-020 Illegal: unknown opcode, R-type funct7 not 0000000/0100000 (or 0100000 with funct3 other than 000/101), shift-immediate with imm[11:5] invalid, branch funct3 010/011; decoded as add, operands 0, IllegalE=1.
REQ-021 Latency: decode captured on the rising edge where reset=0, FlushE=0, StallE=0; outputs valid one cycle after.
REQ-022 ValidE SHALL take ValidD on load; IllegalE SHALL be 0 whenever loaded ValidD=0.
REQ-023 Priority per edge: reset > FlushE > StallE > load.
REQ-024 Flush SHALL load bubble: ValidE=0, IllegalE=0, ALUOpCodeE=0000, SrcAE=SrcBE=0.
REQ-025 Stall SHALL hold every output unchanged for any number of cycles; FlushE with StallE asserted SHALL flush.
REQ-026 Outputs SHALL be driven only from registers (no combinational path InstrD -> outputs).

Reset
REQ-027 On reset all outputs SHALL be 0 (bubble) at the next edge, overriding flush, stall, and load in progress.
REQ-028 Deasserting reset SHALL resume normal loading on the following edge.

Structure
REQ-029 Shared package alu_pkg SHALL hold the 4-bit ALU opcode enum and RISC-V major-opcode constants; the Execute ALU SHALL import the same enum.
REQ-030 Combinational decode SHALL live in sub-module alu_decoder (InstrD -> opcode, operand selects, illegal); id_ex_alu_ctrl holds operand muxes and the register.

Verification
REQ-031 Load 0x40B50533 (sub x10,x10,x11), RD1D=7, RD2D=3 -> next cycle ALUOpCodeE=0001, SrcAE=7, SrcBE=3, ValidE=1.
REQ-032 Load 0x40335293 (srai x5,x6,3), ImmExtD=0x403 -> ALUOpCodeE=0111, SrcBE=0x403, IllegalE=0.
REQ-033 Load bltu (opcode 1100011, funct3 110), then StallE=1 three cycles while InstrD changes -> ALUOpCodeE=1001 held all three cycles.
REQ-034 Load 0x000120B7-style lui, ImmExtD=0x12345000, PCD=0x100 -> SrcAE=0, SrcBE=0x12345000, ALUOpCodeE=0000.
REQ-035 Load 0x00000000 with ValidD=1 -> IllegalE=1, ALUOpCodeE=0000; next edge FlushE=1 and StallE=1 together -> all outputs 0.
REQ-036 Assert reset during a stall with ValidE=1 -> next edge all outputs 0; deassert, load add -> ALUOpCodeE=0000, ValidE=1 one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit Execute ALU opcode, RISC-V major opcodes,
// and operand-select encodings used between the decoder and the ID/EX stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SRCA_ZERO = 2'd0,
    SRCA_RS1  = 2'd1,
    SRCA_PC   = 2'd2
  } srca_sel_e;

  typedef enum logic [1:0] {
    SRCB_ZERO = 2'd0,
    SRCB_RS2  = 2'd1,
    SRCB_IMM  = 2'd2
  } srcb_sel_e;

  // funct3 -> ALU op; alt selects sub (000) or arithmetic shift (101)
  function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of a RISC-V instruction word into an ALU opcode,
// operand selects and an illegal flag. Illegal encodings fall back to add
// with both operands forced to zero.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output alu_op_e     o_alu_op,
  output srca_sel_e   o_sel_a,
  output srcb_sel_e   o_sel_b,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_instr;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // Register and rd fields are irrelevant to ALU control.
  assign w_unused_instr = ^i_instr[24:15] ^ ^i_instr[11:7];

  // Decode opcode/funct fields; illegal encodings override to a zeroed add.
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_sel_a   = SRCA_ZERO;
    o_sel_b   = SRCB_ZERO;
    o_illegal = 1'b0;
    case (w_opcode)
      OPC_RTYPE: begin
        o_sel_a  = SRCA_RS1;
        o_sel_b  = SRCB_RS2;
        o_alu_op = funct3_op(w_funct3, w_funct7 == F7_ALT);
        if (!((w_funct7 == F7_BASE) ||
              ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))))
          o_illegal = 1'b1;
      end
      OPC_IALU: begin
        o_sel_a  = SRCA_RS1;
        o_sel_b  = SRCB_IMM;
        // No subi: alt only matters for the right-shift funct3.
        o_alu_op = funct3_op(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == F7_ALT));
        if ((w_funct3 == 3'b001) && (w_funct7 != F7_BASE))
          o_illegal = 1'b1;
        if ((w_funct3 == 3'b101) && (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT))
          o_illegal = 1'b1;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        o_sel_a = SRCA_RS1;
        o_sel_b = SRCB_IMM;
      end
      OPC_BRANCH: begin
        o_sel_a = SRCA_RS1;
        o_sel_b = SRCB_RS2;
        case (w_funct3[2:1])
          2'b00:   o_alu_op = ALU_SUB;
          2'b10:   o_alu_op = ALU_SLT;
          2'b11:   o_alu_op = ALU_SLTU;
          default: o_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        o_sel_b = SRCB_IMM;
      end
      OPC_AUIPC, OPC_JAL: begin
        o_sel_a = SRCA_PC;
        o_sel_b = SRCB_IMM;
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_alu_op = ALU_ADD;
      o_sel_a  = SRCA_ZERO;
      o_sel_b  = SRCB_ZERO;
    end
  end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register for ALU control: decodes the Decode-stage
// instruction, muxes operands and registers them for Execute. All outputs
// come straight from flops. Per-edge priority: reset > flush > stall > load.
module id_ex_alu_ctrl
  import alu_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallE,
  input  logic         FlushE,
  input  logic         ValidD,
  input  logic [31:0]  InstrD,
  input  logic [M-1:0] RD1D,
  input  logic [M-1:0] RD2D,
  input  logic [M-1:0] ImmExtD,
  input  logic [M-1:0] PCD,
  output logic [3:0]   ALUOpCodeE,
  output logic [M-1:0] SrcAE,
  output logic [M-1:0] SrcBE,
  output logic         ValidE,
  output logic         IllegalE
);

  alu_op_e     w_alu_op;
  srca_sel_e   w_sel_a;
  srcb_sel_e   w_sel_b;
  logic        w_illegal;
  logic [M-1:0] w_src_a;
  logic [M-1:0] w_src_b;

  alu_op_e      r_alu_op;
  logic [M-1:0] r_src_a;
  logic [M-1:0] r_src_b;
  logic         r_valid;
  logic         r_illegal;

  alu_decoder u_dec (
    .i_instr  (InstrD),
    .o_alu_op (w_alu_op),
    .o_sel_a  (w_sel_a),
    .o_sel_b  (w_sel_b),
    .o_illegal(w_illegal)
  );

  // Operand muxes driven by the decoder selects.
  always_comb begin
    w_src_a = '0;
    w_src_b = '0;
    case (w_sel_a)
      SRCA_RS1: w_src_a = RD1D;
      SRCA_PC:  w_src_a = PCD;
      default:  w_src_a = '0;
    endcase
    case (w_sel_b)
      SRCB_RS2: w_src_b = RD2D;
      SRCB_IMM: w_src_b = ImmExtD;
      default:  w_src_b = '0;
    endcase
  end

  // ID/EX register: reset and flush load a bubble, stall holds, else load.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_alu_op  <= ALU_ADD;
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!StallE) begin
      r_alu_op  <= w_alu_op;
      r_src_a   <= w_src_a;
      r_src_b   <= w_src_b;
      r_valid   <= ValidD;
      r_illegal <= ValidD & w_illegal;
    end
  end

  assign ALUOpCodeE = r_alu_op;
  assign SrcAE      = r_src_a;
  assign SrcBE      = r_src_b;
  assign ValidE     = r_valid;
  assign IllegalE   = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: a reference decoder model predicts each edge's
// register contents; predictions go into a queue and are popped after the edge.
module tb_id_ex_alu_ctrl;

  localparam int M = 32;
  localparam int W = 2 + 4 + 2 * M;

  logic         clk;
  logic         reset;
  logic         StallE;
  logic         FlushE;
  logic         ValidD;
  logic [31:0]  InstrD;
  logic [M-1:0] RD1D;
  logic [M-1:0] RD2D;
  logic [M-1:0] ImmExtD;
  logic [M-1:0] PCD;
  logic [3:0]   ALUOpCodeE;
  logic [M-1:0] SrcAE;
  logic [M-1:0] SrcBE;
  logic         ValidE;
  logic         IllegalE;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  logic [W-1:0] got;
  logic [W-1:0] e;
  int n_checks;
  int n_errors;

  id_ex_alu_ctrl #(.M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallE    (StallE),
    .FlushE    (FlushE),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .RD1D      (RD1D),
    .RD2D      (RD2D),
    .ImmExtD   (ImmExtD),
    .PCD       (PCD),
    .ALUOpCodeE(ALUOpCodeE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .ValidE    (ValidE),
    .IllegalE  (IllegalE)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {valid, illegal, op, srcA, srcB} for a loaded instruction
  function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [M-1:0] a,
                                         input logic [M-1:0] b, input logic [M-1:0] imm,
                                         input logic [M-1:0] pc, input logic v);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op;
    logic [M-1:0] sa;
    logic [M-1:0] sb;
    logic ill;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    op = 4'h0; sa = '0; sb = '0; ill = 1'b0;
    case (opc)
      7'h33: begin
        sa = a; sb = b;
        case (f3)
          3'd0: op = (f7 == 7'h20) ? 4'd1 : 4'd0;
          3'd1: op = 4'd5;
          3'd2: op = 4'd8;
          3'd3: op = 4'd9;
          3'd4: op = 4'd2;
          3'd5: op = (f7 == 7'h20) ? 4'd7 : 4'd6;
          3'd6: op = 4'd3;
          default: op = 4'd4;
        endcase
        if (f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ill = 1'b1;
      end
      7'h13: begin
        sa = a; sb = imm;
        case (f3)
          3'd0: op = 4'd0;
          3'd1: begin op = 4'd5; if (f7 != 7'h00) ill = 1'b1; end
          3'd2: op = 4'd8;
          3'd3: op = 4'd9;
          3'd4: op = 4'd2;
          3'd5: begin
            if (f7 == 7'h20) op = 4'd7;
            else if (f7 == 7'h00) op = 4'd6;
            else ill = 1'b1;
          end
          3'd6: op = 4'd3;
          default: op = 4'd4;
        endcase
      end
      7'h03, 7'h23, 7'h67: begin sa = a; sb = imm; end
      7'h63: begin
        sa = a; sb = b;
        if (f3 == 3'd0 || f3 == 3'd1) op = 4'd1;
        else if (f3 == 3'd4 || f3 == 3'd5) op = 4'd8;
        else if (f3 == 3'd6 || f3 == 3'd7) op = 4'd9;
        else ill = 1'b1;
      end
      7'h37: sb = imm;
      7'h17, 7'h6f: begin sa = pc; sb = imm; end
      default: ill = 1'b1;
    endcase
    if (ill) begin op = 4'h0; sa = '0; sb = '0; end
    return {v, ill & v, op, sa, sb};
  endfunction

  // driver: set inputs for the coming edge and push the predicted result
  task automatic apply(input logic rst, input logic fl, input logic st, input logic v,
                       input logic [31:0] ins, input logic [M-1:0] a, input logic [M-1:0] b,
                       input logic [M-1:0] imm, input logic [M-1:0] pc);
    reset = rst; FlushE = fl; StallE = st; ValidD = v;
    InstrD = ins; RD1D = a; RD2D = b; ImmExtD = imm; PCD = pc;
    if (rst || fl) cur_exp = '0;
    else if (!st) cur_exp = model(ins, a, b, imm, pc, v);
    exp_q.push_back(cur_exp);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h00B50533, 32'd1, 32'd2, 32'd3, 32'd4);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || got !== '0) begin
      n_errors++; $display("FAIL reset got %h exp %h", got, e);
    end
  endtask

  task automatic test_sub();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h40B50533, 32'd7, 32'd3, 32'h55, 32'h40);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || ALUOpCodeE !== 4'b0001 || SrcAE !== 32'd7 || SrcBE !== 32'd3 || ValidE !== 1'b1) begin
      n_errors++; $display("FAIL sub got %h exp %h", got, e);
    end
  endtask

  task automatic test_srai();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h40335293, 32'h80000000, 32'd9, 32'h403, 32'h44);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || ALUOpCodeE !== 4'b0111 || SrcBE !== 32'h403 || IllegalE !== 1'b0) begin
      n_errors++; $display("FAIL srai got %h exp %h", got, e);
    end
  endtask

  task automatic test_stall();
    logic [31:0] bltu;
    bltu = {7'd0, 5'd11, 5'd10, 3'b110, 5'd8, 7'h63};
    apply(1'b0, 1'b0, 1'b0, 1'b1, bltu, 32'd5, 32'd9, 32'h10, 32'h48);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || ALUOpCodeE !== 4'b1001) begin
      n_errors++; $display("FAIL bltu_load got %h exp %h", got, e);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h00B50533 + (i << 12), $urandom, $urandom, $urandom, $urandom);
      @(posedge clk); #1;
      got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e || ALUOpCodeE !== 4'b1001 || SrcAE !== 32'd5 || SrcBE !== 32'd9) begin
        n_errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, got, e);
      end
    end
  endtask

  task automatic test_lui();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h000120B7, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'h100);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || SrcAE !== 32'd0 || SrcBE !== 32'h12345000 || ALUOpCodeE !== 4'b0000) begin
      n_errors++; $display("FAIL lui got %h exp %h", got, e);
    end
  endtask

  task automatic test_illegal_flush();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'd11, 32'd12, 32'd13, 32'd14);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || IllegalE !== 1'b1 || ALUOpCodeE !== 4'b0000 || SrcAE !== 32'd0) begin
      n_errors++; $display("FAIL illegal got %h exp %h", got, e);
    end
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h00B50533, 32'd1, 32'd2, 32'd3, 32'd4);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || got !== '0) begin
      n_errors++; $display("FAIL flush_with_stall got %h exp %h", got, e);
    end
  endtask

  task automatic test_reset_during_stall();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h00B50533, 32'd21, 32'd22, 32'd0, 32'd0);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || ValidE !== 1'b1) begin
      n_errors++; $display("FAIL pre_stall_load got %h exp %h", got, e);
    end
    apply(1'b1, 1'b0, 1'b1, 1'b1, 32'h40B50533, 32'd5, 32'd6, 32'd0, 32'd0);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || got !== '0) begin
      n_errors++; $display("FAIL reset_over_stall got %h exp %h", got, e);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h00B50533, 32'd30, 32'd31, 32'd0, 32'd0);
    @(posedge clk); #1;
    got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || ALUOpCodeE !== 4'b0000 || ValidE !== 1'b1 || SrcAE !== 32'd30) begin
      n_errors++; $display("FAIL add_after_reset got %h exp %h", got, e);
    end
  endtask

  // random back-to-back traffic with mixed reset/flush/stall and instruction classes
  task automatic test_back_to_back();
    logic [6:0] opc_tbl [10];
    logic [31:0] ins;
    logic [6:0] f7_tbl [3];
    opc_tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h0b};
    f7_tbl = '{7'h00, 7'h20, 7'h01};
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = opc_tbl[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) != 0) ins[31:25] = f7_tbl[$urandom_range(0, 2)];
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom, $urandom);
      @(posedge clk); #1;
      got = {ValidE, IllegalE, ALUOpCodeE, SrcAE, SrcBE};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++; $display("FAIL rand[%0d] ins %h got %h exp %h", i, ins, got, e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cur_exp = '0;
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0;
    InstrD = '0; RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0;
    @(posedge clk); #1;
    test_reset();
    test_sub();
    test_srai();
    test_stall();
    test_lui();
    test_illegal_flush();
    test_reset_during_stall();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL queue_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
